// File: rtl/reflet_float_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reflet_float_pkg
//  Purpose  : Values and helpers shared by the Reflet FPU blocks (divider,
//             multiplier, int/float converters): binary32 field widths,
//             bias, canonical quiet NaN, divider state encoding, and
//             unpack/pack helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package reflet_float_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_W    = 8;
  localparam int          MANT_W   = 23;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    DIV   = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } div_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  // Subnormals are flushed to a signed zero: exponent field 0 means zero.
  function automatic fp32_t fp_unpack(input logic [31:0] v);
    fp32_t f;
    f = v;
    if (f.exp == '0) f.mant = '0;
    return f;
  endfunction

  function automatic logic [31:0] fp_pack(input logic             sign,
                                          input logic [EXP_W-1:0]  exp,
                                          input logic [MANT_W-1:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage
`default_nettype wire

// File: rtl/reflet_float_round.sv
`default_nettype none
// ============================================================================
//  Module   : reflet_float_round
//  Purpose  : Combinational normalize + round-to-nearest-even + range packing
//             for a 26-bit quotient/product significand in (0.5, 2).
//  Ports    : i_sign    result sign
//             i_exp     biased exponent before normalization (10-bit signed)
//             i_quo     26-bit significand, bit 25 has weight 1.0
//             i_rem_nz  any nonzero bits below i_quo (sticky source)
//             o_result  packed binary32 result (no subnormal output)
//             o_overflow/o_underflow/o_inexact  (REFLET_FLOAT_DIV_STATUS_EN)
//  Revision : 1.0  initial release
// ============================================================================
module reflet_float_round
  import reflet_float_pkg::*;
(
  input  logic              i_sign,
  input  logic signed [9:0] i_exp,
  input  logic [25:0]       i_quo,
  input  logic              i_rem_nz,
  output logic [31:0]       o_result
`ifdef REFLET_FLOAT_DIV_STATUS_EN
  ,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_inexact
`endif
);

  logic [23:0]       w_sig;
  logic              w_guard;
  logic              w_sticky;
  logic              w_round_up;
  logic [24:0]       w_sig_rnd;
  logic [22:0]       w_mant;
  logic signed [9:0] w_exp_norm;
  logic signed [9:0] w_exp_fin;
  logic              w_ovf;
  logic              w_unf;

  always_comb begin
    if (i_quo[25]) begin
      w_sig      = i_quo[25:2];
      w_guard    = i_quo[1];
      w_sticky   = i_quo[0] | i_rem_nz;
      w_exp_norm = i_exp;
    end else begin
      w_sig      = i_quo[24:1];
      w_guard    = i_quo[0];
      w_sticky   = i_rem_nz;
      w_exp_norm = i_exp - 10'sd1;
    end
    w_round_up = w_guard & (w_sticky | w_sig[0]);
    w_sig_rnd  = {1'b0, w_sig} + {24'd0, w_round_up};
    // A carry out means the significand became exactly 2.0: renormalize.
    w_mant     = w_sig_rnd[24] ? w_sig_rnd[23:1] : w_sig_rnd[22:0];
    w_exp_fin  = w_exp_norm + (w_sig_rnd[24] ? 10'sd1 : 10'sd0);
    w_ovf      = (w_exp_fin >= 10'sd255);
    w_unf      = (w_exp_fin <= 10'sd0);
    if (w_ovf)      o_result = fp_pack(i_sign, 8'hFF, 23'd0);
    else if (w_unf) o_result = fp_pack(i_sign, 8'h00, 23'd0);
    else            o_result = fp_pack(i_sign, w_exp_fin[7:0], w_mant);
  end

`ifdef REFLET_FLOAT_DIV_STATUS_EN
  assign o_overflow  = w_ovf;
  assign o_underflow = w_unf;
  assign o_inexact   = w_guard | w_sticky | w_ovf | w_unf;
`endif

endmodule
`default_nettype wire

// File: rtl/reflet_float_div.sv
`default_nettype none
// ============================================================================
//  Module   : reflet_float_div
//  Purpose  : Sequential IEEE-754 binary32 divider, quot = in1 / in2.
//             Restoring division retiring BITS_PER_CYCLE (1 or 2) quotient
//             bits per cycle, start/busy/done handshake.
//  Ports    : clk    rising-edge clock
//             reset  asynchronous active-low reset
//             start  request pulse, sampled only in IDLE
//             in1    dividend (binary32)      in2  divisor (binary32)
//             busy   high from cycle after accepted start until done
//             done   one-cycle pulse, quot valid
//             quot   result, held until the next result
//             flags  {invalid, div_by_zero, overflow, underflow, inexact},
//                    present only with REFLET_FLOAT_DIV_STATUS_EN defined
//  Revision : 1.0  initial release
// ============================================================================
module reflet_float_div
  import reflet_float_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot
`ifdef REFLET_FLOAT_DIV_STATUS_EN
  ,
  output logic [4:0]  flags
`endif
);

  localparam logic [4:0] c_DIV_CYCLES = 5'(26 / BITS_PER_CYCLE);

  div_state_t        r_state, w_state_nxt;
  logic [31:0]       r_a, r_b, r_quot;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [24:0]       r_rem, w_rem_nxt;
  logic [23:0]       r_div;
  logic [25:0]       r_quo, w_quo_nxt;
  logic [4:0]        r_cnt;

  fp32_t             w_a, w_b;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic              w_sign, w_special;
  logic [31:0]       w_spec_res, w_round_res;
  logic signed [9:0] w_exp_raw;

  assign w_a      = fp_unpack(r_a);
  assign w_b      = fp_unpack(r_b);
  assign w_a_zero = (w_a.exp == 8'h00);
  assign w_b_zero = (w_b.exp == 8'h00);
  assign w_a_inf  = (w_a.exp == 8'hFF) && (w_a.mant == '0);
  assign w_b_inf  = (w_b.exp == 8'hFF) && (w_b.mant == '0);
  assign w_a_nan  = (w_a.exp == 8'hFF) && (w_a.mant != '0);
  assign w_b_nan  = (w_b.exp == 8'hFF) && (w_b.mant != '0);
  assign w_sign   = w_a.sign ^ w_b.sign;
  // Modulo-1024 arithmetic gives the correct two's-complement value.
  assign w_exp_raw = 10'({2'b00, w_a.exp}) - 10'({2'b00, w_b.exp}) + 10'(EXP_BIAS);

`ifdef REFLET_FLOAT_DIV_STATUS_EN
  logic [4:0] r_flags, w_spec_flags;
  logic       w_rnd_ovf, w_rnd_unf, w_rnd_inx;
`endif

  // Special-case resolution in PREP; priority order matters (NaN first).
  always_comb begin
    w_special  = 1'b1;
    w_spec_res = QNAN;
`ifdef REFLET_FLOAT_DIV_STATUS_EN
    w_spec_flags = 5'b00000;
`endif
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res = QNAN;
`ifdef REFLET_FLOAT_DIV_STATUS_EN
      w_spec_flags = 5'b10000;
`endif
    end else if (w_b_zero) begin
      w_spec_res = fp_pack(w_sign, 8'hFF, 23'd0);
`ifdef REFLET_FLOAT_DIV_STATUS_EN
      w_spec_flags = {1'b0, ~w_a_inf, 3'b000};
`endif
    end else if (w_a_inf) begin
      w_spec_res = fp_pack(w_sign, 8'hFF, 23'd0);
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res = fp_pack(w_sign, 8'h00, 23'd0);
    end else begin
      w_special = 1'b0;
    end
  end

  // Restoring division: BITS_PER_CYCLE compare/subtract/shift steps.
  always_comb begin
    w_rem_nxt = r_rem;
    w_quo_nxt = r_quo;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (w_rem_nxt >= {1'b0, r_div}) begin
        w_rem_nxt = w_rem_nxt - {1'b0, r_div};
        w_quo_nxt = {w_quo_nxt[24:0], 1'b1};
      end else begin
        w_quo_nxt = {w_quo_nxt[24:0], 1'b0};
      end
      w_rem_nxt = w_rem_nxt << 1;
    end
  end

  reflet_float_round u_round (
    .i_sign   (r_sign),
    .i_exp    (r_exp),
    .i_quo    (r_quo),
    .i_rem_nz (r_rem != '0),
    .o_result (w_round_res)
`ifdef REFLET_FLOAT_DIV_STATUS_EN
    ,
    .o_overflow  (w_rnd_ovf),
    .o_underflow (w_rnd_unf),
    .o_inexact   (w_rnd_inx)
`endif
  );

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = PREP;
      PREP:  begin
        busy        = 1'b1;
        w_state_nxt = w_special ? DONE : DIV;
      end
      DIV:   begin
        busy = 1'b1;
        if (r_cnt == 5'd1) w_state_nxt = ROUND;
      end
      ROUND: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE:  begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_quot  <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (start) begin
          r_a <= in1;
          r_b <= in2;
        end
        PREP: begin
          r_sign <= w_sign;
          r_exp  <= w_exp_raw;
          r_rem  <= {2'b01, w_a.mant};
          r_div  <= {1'b1, w_b.mant};
          r_quo  <= '0;
          r_cnt  <= c_DIV_CYCLES;
          if (w_special) r_quot <= w_spec_res;
        end
        DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 5'd1;
        end
        ROUND: r_quot <= w_round_res;
        default: ;
      endcase
    end
  end

  assign quot = r_quot;

`ifdef REFLET_FLOAT_DIV_STATUS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else if (r_state == PREP && w_special) begin
      r_flags <= w_spec_flags;
    end else if (r_state == ROUND) begin
      r_flags <= {2'b00, w_rnd_ovf, w_rnd_unf, w_rnd_inx};
    end
  end
  assign flags = r_flags;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reflet_float_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reflet_float_div
//  Purpose  : Self-checking bench for reflet_float_div: directed literal
//             cases, handshake/reset cases and randomized operands compared
//             against an arithmetic reference model of binary32 division.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reflet_float_div;

  localparam int BPC = 1;

  typedef struct {
    logic [31:0] q;
    logic [4:0]  f;
    int          lat;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in1, in2;
  logic        busy, done;
  logic [31:0] quot;
`ifdef REFLET_FLOAT_DIV_STATUS_EN
  logic [4:0]  flags;
`endif

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  reflet_float_div #(.BITS_PER_CYCLE(BPC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .quot  (quot)
`ifdef REFLET_FLOAT_DIV_STATUS_EN
    ,
    .flags (flags)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference: exact long division of the 24-bit significands, then RNE.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int ea, eb, e, p, sh;
    logic s;
    bit za, zb, ia, ib, na, nb, up, inx;
    longint unsigned ma, mb, q, rm, sig, rest, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    s  = a[31] ^ b[31];
    r.f = 5'b0;
    r.lat = 2;
    r.due = 0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r.q = 32'h7FC00000;
      r.f = 5'b10000;
    end else if (zb) begin
      r.q = {s, 8'hFF, 23'h0};
      r.f = ia ? 5'b00000 : 5'b01000;
    end else if (ia) begin
      r.q = {s, 8'hFF, 23'h0};
    end else if (za || ib) begin
      r.q = {s, 31'h0};
    end else begin
      r.lat = 2 + 26 / BPC + 1;
      ma = {40'd0, 1'b1, a[22:0]};
      mb = {40'd0, 1'b1, b[22:0]};
      q  = (ma << 40) / mb;
      rm = (ma << 40) % mb;
      p  = (q >= (64'd1 << 40)) ? 40 : 39;
      sh = p - 23;
      sig  = q >> sh;
      rest = q & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      e   = ea - eb + 127 + (p - 40);
      inx = (rest != 0) || (rm != 0);
      up  = (rest > half) || ((rest == half) && ((rm != 0) || ((sig & 1) != 0)));
      if (up) sig = sig + 1;
      if (sig == (64'd1 << 24)) begin
        sig = sig >> 1;
        e   = e + 1;
      end
      if (e >= 255) begin
        r.q = {s, 8'hFF, 23'h0};
        r.f = 5'b00101;
      end else if (e <= 0) begin
        r.q = {s, 31'h0};
        r.f = 5'b00011;
      end else begin
        r.q = {s, 8'(e), 23'(sig)};
        r.f = {4'b0000, inx};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       v[30:23] = 8'h00;
      1:       v[30:23] = 8'hFF;
      2:       v[30:23] = 8'h01;
      3:       v[30:23] = 8'hFE;
      4:       v[22:0]  = 23'h0;
      default: v[30:23] = 8'($urandom_range(64, 190));
    endcase
    return v;
  endfunction

  // Compare process: busy every cycle a transaction is pending, result on done.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("busy", {31'd0, busy}, {31'd0, (cyc < e.due)});
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("quot", quot, e.q);
          chk("latency", cyc, e.due);
`ifdef REFLET_FLOAT_DIV_STATUS_EN
          chk("flags", {27'd0, flags}, {27'd0, e.f});
`endif
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input bit lit, input logic [31:0] lq, input logic [4:0] lf);
    exp_t e;
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(a, b);
    if (lit) begin
      e.q = lq;
      e.f = lf;
    end
    e.due = cyc + e.lat - 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL timeout: got no done within 100 cycles, expected done");
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t m;
    reset = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quot", quot, 32'h0);
`ifdef REFLET_FLOAT_DIV_STATUS_EN
    chk("reset_flags", {27'd0, flags}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Pin the reference model with hand-computed values.
    m = model(32'h40C00000, 32'h40000000);
    chk("model_6_2", m.q, 32'h40400000);
    chk("model_lat", m.lat, (BPC == 1) ? 29 : 16);
    m = model(32'h3F800000, 32'h40400000);
    chk("model_1_3", m.q, 32'h3EAAAAAB);
    m = model(32'hC0F00000, 32'h00000000);
    chk("model_divz", m.q, 32'hFF800000);
    m = model(32'h7F7FFFFF, 32'h00800000);
    chk("model_ovf", m.q, 32'h7F800000);

    // Directed cases with literal expectations.
    issue(32'h40C00000, 32'h40000000, 1, 32'h40400000, 5'b00000); wait_idle();
    issue(32'h3F800000, 32'h40400000, 1, 32'h3EAAAAAB, 5'b00001); wait_idle();
    issue(32'h40000000, 32'h3F800000, 1, 32'h40000000, 5'b00000); wait_idle();
    issue(32'hC0F00000, 32'h00000000, 1, 32'hFF800000, 5'b01000); wait_idle();
    issue(32'h00000000, 32'h00000000, 1, 32'h7FC00000, 5'b10000); wait_idle();
    issue(32'h00000000, 32'h40A00000, 1, 32'h00000000, 5'b00000); wait_idle();
    issue(32'h7F7FFFFF, 32'h00800000, 1, 32'h7F800000, 5'b00101); wait_idle();
    issue(32'h00800000, 32'h40000000, 1, 32'h00000000, 5'b00011); wait_idle();

    // Start while busy is ignored.
    issue(32'h40C00000, 32'h40000000, 1, 32'h40400000, 5'b00000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    in1   = 32'h3F800000;
    in2   = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-divide.
    issue(32'h41200000, 32'h40400000, 0, 32'h0, 5'b0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_quot", quot, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    issue(32'h41200000, 32'h40400000, 0, 32'h0, 5'b0); wait_idle();

    // Randomized operands against the model.
    for (int i = 0; i < 150; i++) begin
      issue(rand_fp(), rand_fp(), 0, 32'h0, 5'b0);
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
